gf180mcu_osu_sc_12t_dlat_rf: RTL and testbench
==============================================

# gf180mcu_osu_sc_12T_dlat_rf

Parametrised latch-style register file: the multi-bit, multi-entry successor of the 12T single-bit D latch. It holds DEPTH words of WIDTH bits, and writes through a valid/ready port. A selectable mode gives either latch-transparent write-through reads or registered reads. A built-in clear sequencer initialises every entry after reset or on request. It is the behavioural/RTL model used wherever a small latch-based storage array is instantiated in GF180 12T digital blocks.

## Interface
- WIDTH, 8: data bits per entry (≥1).
- DEPTH, 8: number of entries (≥2); AW = $clog2(DEPTH).
- MODE, 0: 0 = transparent (write data visible on Q in the same cycle); 1 = registered (visible after the write edge).
- CLR_VAL, 0: WIDTH-bit value written by the clear sequencer.

Ports:
- CLK  input  1  clock; all state updates occur on the rising edge.
- RN  input  1  reset; synchronous, active-low.
- CLR  input  1  request for a full clear of all entries.
- WE  input  1  write valid.
- WRDY  output  1  write ready; a write is accepted when WE && WRDY at a rising edge.
- WA  input  AW  write address.
- D  input  WIDTH  write data.
- RA  input  AW  read address.
- Q  output  WIDTH  read data; combinational from RA and state.
- BUSY  output  1  clear sequence in progress.

## Operation
- States: CLEAR, IDLE. Pointer cptr holds AW bits.
- Any rising edge with RN=0: state←CLEAR, cptr←0. Storage is not written on this edge.
- CLEAR, RN=1: mem[cptr]←CLR_VAL, cptr←cptr+1. When cptr==DEPTH-1, state←IDLE and cptr←0.
- IDLE with CLR=1: state←CLEAR, cptr←0. No entry is written on that edge.
- CLEAR with CLR=1: the pointer restarts at 0; entry 0 is cleared on that edge.
- WRDY = RN && (state==IDLE) && !CLR. Reset and CLR take priority over writes, and a write offered with CLR high is dropped.
- Accepted write: mem[WA]←D. If WA≥DEPTH (non-power-of-2 DEPTH), the write is accepted and discarded.
- Q while BUSY: CLR_VAL.
- Q in IDLE, MODE=0: D if WE && WRDY && WA==RA, otherwise mem[RA].
- Q in IDLE, MODE=1: mem[RA].
- Q for RA≥DEPTH: CLR_VAL.
- BUSY = (state==CLEAR). A WE held through CLEAR is accepted on the first IDLE edge, provided CLR=0.

## Timing
- Values while RN=0 (after the first edge): BUSY=1, WRDY=0, Q=CLR_VAL.
- Clear latency: DEPTH rising edges with RN=1. Edge k (1..DEPTH) clears entry k-1.
- After clear: BUSY=0 and WRDY=1 following edge DEPTH. For DEPTH=8, the first write is accepted on edge 9.
- RN falling mid-clear aborts the clear; the count restarts from edge 1 after RN returns high.
- Write-to-read latency: 0 cycles in MODE=0, 1 edge in MODE=1.
- Back-to-back writes: one per cycle, no bubbles.
- Simultaneous write and read of a different address: Q shows the old mem[RA], unaffected by the write.

## Structure
- Package gf180mcu_osu_sc_dlat_rf_pkg holds:
  - the state enum {CLEAR, IDLE};
  - MODE_TRANSPARENT=0 and MODE_REGISTERED=1;
  - a function computing AW (minimum 1).
- Sub-module gf180mcu_osu_sc_12T_dlat_rf_clrseq contains the FSM and cptr, with outputs BUSY, clr_we and clr_addr. The top level contains the storage array, the write mux (clear vs user write) and the read/bypass mux.
- No specify block; timing annotation is handled separately at cell level.

## Test plan
- Reset and clear: RN=0 for 2 edges, then 1. Required: BUSY=1 for exactly 8 edges (DEPTH=8), WRDY rises after edge 8, and every RA reads 0x00.
- Write/read, MODE=0: write WA=3, D=0xA5 with RA=3. Required: Q=0xA5 in the same cycle and after the edge; RA=4 reads 0x00.
- Write/read, MODE=1: same stimulus. Required: Q=0x00 before the edge and 0xA5 after it.
- CLR vs write: CLR=1 together with WE=1, WA=2, D=0x5A. Required: WRDY=0, no write, a DEPTH-cycle clear follows, and mem[2] reads CLR_VAL.
- Reset mid-clear: RN low at clear edge 4 for 1 edge. Required: the count restarts, and BUSY stays high for 8 further edges.
- Non-power-of-2 (DEPTH=6): write WA=7. Required: accepted with no effect, entries 0–5 unchanged, and RA=7 reads CLR_VAL.

Source files
------------

// File: rtl/gf180mcu_osu_sc_12t_dlat_rf_pkg.sv
// Shared types and helpers for the latch-style register file.
package gf180mcu_osu_sc_dlat_rf_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } rf_state_e;

  localparam int MODE_TRANSPARENT = 0;
  localparam int MODE_REGISTERED  = 1;

  // Address width for a given depth, never narrower than one bit.
  function automatic int calc_aw(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_12t_dlat_rf_if.sv
// Write (valid/ready) and read port bundle of the register file.
interface gf180mcu_osu_sc_12t_dlat_rf_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  import gf180mcu_osu_sc_dlat_rf_pkg::*;

  localparam int AW = calc_aw(DEPTH);

  logic             we;
  logic             wrdy;
  logic [AW-1:0]    wa;
  logic [WIDTH-1:0] d;
  logic [AW-1:0]    ra;
  logic [WIDTH-1:0] q;

  modport master (output we, wa, d, ra, input wrdy, q);
  modport slave  (input we, wa, d, ra, output wrdy, q);

endinterface

// File: rtl/gf180mcu_osu_sc_12t_dlat_rf_clrseq.sv
// Clear sequencer: walks every entry after reset or on a clear request.
//
// state | meaning
// ------+-----------------------------------------------------------
// CLEAR | writing CLR_VAL to entry cptr, one entry per edge; busy
// IDLE  | array available for user writes
module gf180mcu_osu_sc_12t_dlat_rf_clrseq
  import gf180mcu_osu_sc_dlat_rf_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = calc_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          rn,
  input  logic          clr,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] cptr_q, cptr_d;

  // State and pointer registers; reset parks the sequencer at the start of a clear.
  always_ff @(posedge clk) begin
    if (!rn) begin
      state_q <= CLEAR;
      cptr_q  <= '0;
    end else begin
      state_q <= state_d;
      cptr_q  <= cptr_d;
    end
  end

  // Next-state and clear-write decode.
  always_comb begin
    state_d  = state_q;
    cptr_d   = cptr_q;
    clr_we   = 1'b0;
    clr_addr = cptr_q;
    case (state_q)
      CLEAR: begin
        clr_we = rn;
        if (clr) begin
          // A fresh request restarts the walk; entry 0 is cleared on this edge.
          clr_addr = '0;
          cptr_d   = AW'(1);
        end else if (cptr_q == LAST) begin
          state_d = IDLE;
          cptr_d  = '0;
        end else begin
          cptr_d = cptr_q + AW'(1);
        end
      end
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          cptr_d  = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cptr_d  = '0;
      end
    endcase
  end

  assign busy = (state_q == CLEAR);

endmodule

// File: rtl/gf180mcu_osu_sc_12t_dlat_rf.sv
// Latch-style register file: storage array, clear/user write mux and read/bypass mux.
module gf180mcu_osu_sc_12t_dlat_rf
  import gf180mcu_osu_sc_dlat_rf_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 8,
  parameter int               MODE    = MODE_TRANSPARENT,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic clk,
  input  logic rn,
  input  logic clr,
  output logic busy,
  gf180mcu_osu_sc_12t_dlat_rf_if.slave bus
);

  localparam int         AW      = calc_aw(DEPTH);
  localparam bit         POW2    = (DEPTH == (1 << AW));
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic             wr_acc;
  logic             wa_ok;
  logic             ra_ok;

  gf180mcu_osu_sc_12t_dlat_rf_clrseq #(.DEPTH(DEPTH), .AW(AW)) u_clrseq (
    .clk      (clk),
    .rn       (rn),
    .clr      (clr),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign bus.wrdy = rn && !busy && !clr;
  assign wr_acc   = bus.we && bus.wrdy;

  // Addresses past the last entry exist only for non-power-of-2 depths.
  assign wa_ok = POW2 || ({1'b0, bus.wa} < DEPTH_W);
  assign ra_ok = POW2 || ({1'b0, bus.ra} < DEPTH_W);

  // Storage update: clear writes and user writes are mutually exclusive by construction.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= CLR_VAL;
    end else if (wr_acc && wa_ok) begin
      mem[bus.wa] <= bus.d;
    end
  end

  // Read path with optional write-through bypass.
  always_comb begin
    bus.q = CLR_VAL;
    if (!busy && ra_ok) begin
      if ((MODE == MODE_TRANSPARENT) && wr_acc && (bus.wa == bus.ra)) begin
        bus.q = bus.d;
      end else begin
        bus.q = mem[bus.ra];
      end
    end
  end

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_dlat_rf.sv
// Directed bench: transparent/registered DEPTH=8 and transparent DEPTH=6 instances share stimulus.
module tb_gf180mcu_osu_sc_12t_dlat_rf;
  import gf180mcu_osu_sc_dlat_rf_pkg::*;

  logic       clk = 1'b0;
  logic       rn, clr, we;
  logic [2:0] wa, ra;
  logic [7:0] d;
  logic       busy0, busy1, busy2;
  int         n_cmp = 0;
  int         n_err = 0;
  int         c0, c2;

  always #5 clk = ~clk;

  gf180mcu_osu_sc_12t_dlat_rf_if #(.WIDTH(8), .DEPTH(8)) bus0 ();
  gf180mcu_osu_sc_12t_dlat_rf_if #(.WIDTH(8), .DEPTH(8)) bus1 ();
  gf180mcu_osu_sc_12t_dlat_rf_if #(.WIDTH(8), .DEPTH(6)) bus2 ();

  assign bus0.we = we;  assign bus0.wa = wa;  assign bus0.d = d;  assign bus0.ra = ra;
  assign bus1.we = we;  assign bus1.wa = wa;  assign bus1.d = d;  assign bus1.ra = ra;
  assign bus2.we = we;  assign bus2.wa = wa;  assign bus2.d = d;  assign bus2.ra = ra;

  gf180mcu_osu_sc_12t_dlat_rf #(.WIDTH(8), .DEPTH(8), .MODE(MODE_TRANSPARENT), .CLR_VAL(8'h00)) u_dut0 (
    .clk(clk), .rn(rn), .clr(clr), .busy(busy0), .bus(bus0));
  gf180mcu_osu_sc_12t_dlat_rf #(.WIDTH(8), .DEPTH(8), .MODE(MODE_REGISTERED), .CLR_VAL(8'h00)) u_dut1 (
    .clk(clk), .rn(rn), .clr(clr), .busy(busy1), .bus(bus1));
  gf180mcu_osu_sc_12t_dlat_rf #(.WIDTH(8), .DEPTH(6), .MODE(MODE_TRANSPARENT), .CLR_VAL(8'h00)) u_dut2 (
    .clk(clk), .rn(rn), .clr(clr), .busy(busy2), .bus(bus2));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Edges until busy drops on the DEPTH=8 and DEPTH=6 instances; 0 means it never did.
  task automatic measure_clear(output int e0, output int e2);
    e0 = 0;
    e2 = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (!busy0 && e0 == 0) e0 = i;
      if (!busy2 && e2 == 0) e2 = i;
      if (e0 != 0 && e2 != 0) break;
    end
  endtask

  initial begin
    rn = 1'b0; clr = 1'b0; we = 1'b0; wa = '0; ra = '0; d = '0;

    // Reset held for two edges.
    tick(); tick();
    check_val("rst_busy", busy0, 1);
    check_val("rst_wrdy", bus0.wrdy, 0);
    check_val("rst_q", bus0.q, 8'h00);

    rn = 1'b1;
    #1;
    measure_clear(c0, c2);
    check_val("clr_len_d8", c0, 8);
    check_val("clr_len_d6", c2, 6);
    check_val("post_clr_wrdy", bus0.wrdy, 1);
    for (int a = 0; a < 8; a++) begin
      ra = 3'(a);
      #1;
      check_val($sformatf("clr_rd%0d", a), bus0.q, 8'h00);
    end

    // Write entry 3 with read address matching.
    we = 1'b1; wa = 3'd3; d = 8'hA5; ra = 3'd3;
    #1;
    check_val("m0_same_cycle", bus0.q, 8'hA5);
    check_val("m1_before_edge", bus1.q, 8'h00);
    tick();
    we = 1'b0;
    #1;
    check_val("m0_after_edge", bus0.q, 8'hA5);
    check_val("m1_after_edge", bus1.q, 8'hA5);
    ra = 3'd4;
    #1;
    check_val("m0_other_addr", bus0.q, 8'h00);

    // Write to 5 while reading 3: old contents stay visible.
    we = 1'b1; wa = 3'd5; d = 8'h3C; ra = 3'd3;
    #1;
    check_val("diff_addr_q", bus0.q, 8'hA5);
    tick();
    // Back-to-back writes to 0 and 1.
    wa = 3'd0; d = 8'h11;
    tick();
    wa = 3'd1; d = 8'h22;
    tick();
    we = 1'b0;
    ra = 3'd5; #1;
    check_val("rd5_m0", bus0.q, 8'h3C);
    check_val("rd5_m1", bus1.q, 8'h3C);
    ra = 3'd0; #1;
    check_val("b2b_rd0", bus0.q, 8'h11);
    ra = 3'd1; #1;
    check_val("b2b_rd1", bus1.q, 8'h22);

    // Out-of-range write on DEPTH=6 is accepted and discarded.
    we = 1'b1; wa = 3'd7; d = 8'hFF; ra = 3'd7;
    #1;
    check_val("d6_wrdy", bus2.wrdy, 1);
    check_val("d6_oor_q_same", bus2.q, 8'h00);
    tick();
    we = 1'b0;
    #1;
    check_val("d6_oor_q", bus2.q, 8'h00);
    check_val("d8_rd7", bus0.q, 8'hFF);
    ra = 3'd0; #1; check_val("d6_rd0", bus2.q, 8'h11);
    ra = 3'd1; #1; check_val("d6_rd1", bus2.q, 8'h22);
    ra = 3'd2; #1; check_val("d6_rd2", bus2.q, 8'h00);
    ra = 3'd3; #1; check_val("d6_rd3", bus2.q, 8'hA5);
    ra = 3'd4; #1; check_val("d6_rd4", bus2.q, 8'h00);
    ra = 3'd5; #1; check_val("d6_rd5", bus2.q, 8'h3C);

    // Clear request alongside a write: write is dropped, full clear follows.
    clr = 1'b1; we = 1'b1; wa = 3'd2; d = 8'h5A; ra = 3'd2;
    #1;
    check_val("clr_wrdy", bus0.wrdy, 0);
    tick();
    clr = 1'b0; we = 1'b0;
    #1;
    check_val("clr_busy", busy0, 1);
    check_val("clr_busy_q", bus0.q, 8'h00);
    measure_clear(c0, c2);
    check_val("clr_req_len_d8", c0, 8);
    check_val("clr_req_len_d6", c2, 6);
    ra = 3'd2; #1; check_val("clr_rd2", bus0.q, 8'h00);
    ra = 3'd3; #1; check_val("clr_rd3", bus0.q, 8'h00);

    // Reset landing on the fourth clear edge restarts the count.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick(); tick(); tick();
    rn = 1'b0;
    tick();
    rn = 1'b1;
    #1;
    check_val("midclr_busy", busy0, 1);
    check_val("midclr_wrdy", bus0.wrdy, 1'b0);
    measure_clear(c0, c2);
    check_val("midclr_len_d8", c0, 8);
    check_val("midclr_len_d6", c2, 6);
    check_val("midclr_wrdy_after", bus0.wrdy, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
